seed_a_arbiter: RTL and testbench

- Schedules access to the seedA storage block, which holds 128 bits and is streamed as two 64-bit words in and out.
- One loader (refills seedA) and NUM_RD readers (matrix-A generator lanes) request the storage.
- The block issues the storage commands (startIn / startOut) in a fixed order and routes the serialized read stream to the granted reader.
- It prevents reads of an unloaded seed and never lets commands overlap.

---
 rtl/seed_a_arbiter_pkg.sv | 20 ++
 rtl/seed_a_arbiter_rr_pick.sv | 36 +++
 rtl/seed_a_arbiter.sv | 164 ++++++++++++++++
 tb/tb_seed_a_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seed_a_arbiter_pkg.sv
// seed_a_arbiter_pkg: shared types and constants for the seedA storage
// arbiter. It holds the FSM state encoding, the {startIn, startOut} command
// codes and the number of 64-bit words in one 128-bit seed.
package seed_a_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD_LD  = 3'd1,
      ST_LOADING = 3'd2,
      ST_CMD_RD  = 3'd3,
      ST_READING = 3'd4
   } seeda_state_t;

   // Storage command bits are ordered {startIn, startOut}.
   localparam logic [1:0] SEEDA_CMD_LOAD = 2'b10;
   localparam logic [1:0] SEEDA_CMD_READ = 2'b01;

   localparam int unsigned SEEDA_WORDS = 2;

endpackage

// File: rtl/seed_a_arbiter_rr_pick.sv
// seed_a_arbiter_rr_pick: combinational round-robin picker.
// It searches req upward from ptr and wraps around. It returns the index of
// the first set bit and a found flag.
// Ports:
//   req   in  N  request vector
//   ptr   in  W  search start position (0..N-1)
//   idx   out W  chosen index (0 when nothing is found)
//   found out 1  at least one request bit is set
module seed_a_arbiter_rr_pick
   import seed_a_arbiter_pkg::*;
#(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] idx,
   output logic         found
);

   logic [W-1:0] pos;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         pos = W'((int'(ptr) + k) % N);
         if (!found && req[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
   end

endmodule

// File: rtl/seed_a_arbiter.sv
// seed_a_arbiter: schedules access to the 128-bit seedA storage.
// One loader and NUM_RD readers share the storage. The block issues the
// storage load/read commands one at a time. It routes the two-word read
// stream to the granted reader. Reads are held off until a complete seed
// has been loaded.
// Ports:
//   clk, rst (async, active high)
//   ld_req / ld_ack                         loader request / acceptance pulse
//   rd_req, rd_canReceive                   per-reader request / ready
//   rd_data, rd_isReady, rd_isLast          read stream to readers
//   st_cmd, st_cmd_isReady/_canReceive      storage command channel
//   st_out, st_out_isReady/_canReceive/_isLast  storage output stream
//   st_in_fire_last                         storage input last-word monitor
//   seed_valid                              a complete seed is held
//   rd_count (only with SEEDA_ARB_READ_COUNT_EN) saturating count of completed reads
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | waiting; a load wins over reads, reads need seed_valid
// ST_CMD_LD  | load command presented until storage accepts it
// ST_LOADING | storage being filled; wait for its last input word
// ST_CMD_RD  | read command presented for the granted reader
// ST_READING | stream routed to the granted reader until last word
module seed_a_arbiter
   import seed_a_arbiter_pkg::*;
#(
   parameter int NUM_RD   = 2,
   parameter int RD_IDX_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_req,
   output logic              ld_ack,
   input  logic [NUM_RD-1:0] rd_req,
   output logic [63:0]       rd_data,
   output logic [NUM_RD-1:0] rd_isReady,
   input  logic [NUM_RD-1:0] rd_canReceive,
   output logic              rd_isLast,
   output logic [1:0]        st_cmd,
   output logic              st_cmd_isReady,
   input  logic              st_cmd_canReceive,
   input  logic [63:0]       st_out,
   input  logic              st_out_isReady,
   output logic              st_out_canReceive,
   input  logic              st_out_isLast,
   input  logic              st_in_fire_last,
   output logic              seed_valid
`ifdef SEEDA_ARB_READ_COUNT_EN
   ,
   output logic [15:0]       rd_count
`endif
);

   seeda_state_t        state;
   logic [RD_IDX_W-1:0] grant;
   logic [RD_IDX_W-1:0] rr_ptr;
   logic [RD_IDX_W-1:0] pick_idx;
   logic                pick_found;
   logic [RD_IDX_W-1:0] rr_next;
   logic                out_fire;
   logic                ld_fire;

   seed_a_arbiter_rr_pick #(
      .N (NUM_RD),
      .W (RD_IDX_W)
   ) u_rr_pick (
      .req   (rd_req),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign rr_next  = (grant == RD_IDX_W'(NUM_RD - 1)) ? '0 : grant + RD_IDX_W'(1);
   assign out_fire = st_out_isReady & st_out_canReceive;
   assign ld_fire  = (state == ST_CMD_LD) & st_cmd_canReceive;

   // ld_ack must coincide with the command handshake, so it is decoded
   // rather than registered.
   assign ld_ack    = ld_fire;
   assign rd_data   = st_out;
   assign rd_isLast = st_out_isLast;

   always_comb begin
      rd_isReady        = '0;
      st_out_canReceive = 1'b0;
      if (state == ST_READING) begin
         rd_isReady[grant] = st_out_isReady;
         st_out_canReceive = rd_canReceive[grant];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         grant          <= '0;
         rr_ptr         <= '0;
         seed_valid     <= 1'b0;
         st_cmd         <= '0;
         st_cmd_isReady <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ld_req) begin
                  state          <= ST_CMD_LD;
                  st_cmd         <= SEEDA_CMD_LOAD;
                  st_cmd_isReady <= 1'b1;
               end else if (seed_valid && pick_found) begin
                  grant          <= pick_idx;
                  state          <= ST_CMD_RD;
                  st_cmd         <= SEEDA_CMD_READ;
                  st_cmd_isReady <= 1'b1;
               end
            end
            ST_CMD_LD: begin
               if (st_cmd_canReceive) begin
                  // The old seed is being overwritten from here on.
                  seed_valid     <= 1'b0;
                  st_cmd         <= '0;
                  st_cmd_isReady <= 1'b0;
                  state          <= ST_LOADING;
               end
            end
            ST_LOADING: begin
               if (st_in_fire_last) begin
                  seed_valid <= 1'b1;
                  state      <= ST_IDLE;
               end
            end
            ST_CMD_RD: begin
               if (st_cmd_canReceive) begin
                  st_cmd         <= '0;
                  st_cmd_isReady <= 1'b0;
                  state          <= ST_READING;
               end
            end
            ST_READING: begin
               if (out_fire && st_out_isLast) begin
                  rr_ptr <= rr_next;
                  state  <= ST_IDLE;
               end
            end
            default: begin
               state          <= ST_IDLE;
               st_cmd         <= '0;
               st_cmd_isReady <= 1'b0;
            end
         endcase
      end
   end

`ifdef SEEDA_ARB_READ_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_count <= '0;
      end else if (ld_fire) begin
         rd_count <= '0;
      end else if ((state == ST_READING) && out_fire && st_out_isLast &&
                   (rd_count != 16'hFFFF)) begin
         rd_count <= rd_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_seed_a_arbiter.sv
// tb_seed_a_arbiter: directed bench for seed_a_arbiter (NUM_RD = 2).
module tb_seed_a_arbiter;
   import seed_a_arbiter_pkg::*;

   localparam int NUM_RD = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              ld_req;
   logic              ld_ack;
   logic [NUM_RD-1:0] rd_req;
   logic [63:0]       rd_data;
   logic [NUM_RD-1:0] rd_isReady;
   logic [NUM_RD-1:0] rd_canReceive;
   logic              rd_isLast;
   logic [1:0]        st_cmd;
   logic              st_cmd_isReady;
   logic              st_cmd_canReceive;
   logic [63:0]       st_out;
   logic              st_out_isReady;
   logic              st_out_canReceive;
   logic              st_out_isLast;
   logic              st_in_fire_last;
   logic              seed_valid;
`ifdef SEEDA_ARB_READ_COUNT_EN
   logic [15:0]       rd_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seed_a_arbiter #(.NUM_RD(NUM_RD)) dut (
      .clk               (clk),
      .rst               (rst),
      .ld_req            (ld_req),
      .ld_ack            (ld_ack),
      .rd_req            (rd_req),
      .rd_data           (rd_data),
      .rd_isReady        (rd_isReady),
      .rd_canReceive     (rd_canReceive),
      .rd_isLast         (rd_isLast),
      .st_cmd            (st_cmd),
      .st_cmd_isReady    (st_cmd_isReady),
      .st_cmd_canReceive (st_cmd_canReceive),
      .st_out            (st_out),
      .st_out_isReady    (st_out_isReady),
      .st_out_canReceive (st_out_canReceive),
      .st_out_isLast     (st_out_isLast),
      .st_in_fire_last   (st_in_fire_last),
      .seed_valid        (seed_valid)
`ifdef SEEDA_ARB_READ_COUNT_EN
      ,
      .rd_count          (rd_count)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts in IDLE with storage command ready; ends in IDLE with a valid seed.
   task automatic do_load();
      ld_req = 1'b1;
      tick();
      check("ld_cmd", st_cmd, SEEDA_CMD_LOAD);
      check("ld_cmd_vld", st_cmd_isReady, 1);
      check("ld_ack", ld_ack, 1);
      ld_req = 1'b0;
      tick();
      check("ld_ack_pulse", ld_ack, 0);
      check("ld_seed_cleared", seed_valid, 0);
      repeat (2) tick();
      check("ld_no_cmd_while_loading", st_cmd_isReady, 0);
      check("ld_no_rd_while_loading", rd_isReady, 0);
      st_in_fire_last = 1'b1;
      tick();
      st_in_fire_last = 1'b0;
      check("ld_seed_valid", seed_valid, 1);
   endtask

   // Starts in IDLE with rd_req pending; ends in IDLE after both words.
   task automatic do_read(input int g, input logic [63:0] w0, input logic [63:0] w1,
                          input int stall);
      logic [NUM_RD-1:0] exp_oh;
      exp_oh = NUM_RD'(1) << g;
      tick();
      check("rd_cmd", st_cmd, SEEDA_CMD_READ);
      check("rd_cmd_vld", st_cmd_isReady, 1);
      st_out         = w0;
      st_out_isReady = 1'b1;
      st_out_isLast  = 1'b0;
      #1;
      check("rd_no_vld_in_cmd", rd_isReady, 0);
      tick();
      check("rd_cmd_dropped", st_cmd_isReady, 0);
      check("rd_grant_w0", rd_isReady, exp_oh);
      check("rd_data_w0", rd_data, w0);
      check("rd_last_w0", rd_isLast, 0);
      if (stall > 0) begin
         rd_canReceive[g] = 1'b0;
         #1;
         for (int i = 0; i < stall; i++) begin
            check("stall_canrx", st_out_canReceive, 0);
            check("stall_data", rd_data, w0);
            tick();
         end
         rd_canReceive = '1;
         #1;
      end
      check("rd_canrx_w0", st_out_canReceive, 1);
      tick();
      st_out        = w1;
      st_out_isLast = 1'b1;
      #1;
      check("rd_grant_w1", rd_isReady, exp_oh);
      check("rd_data_w1", rd_data, w1);
      check("rd_last_w1", rd_isLast, 1);
      tick();
      st_out_isReady = 1'b0;
      st_out_isLast  = 1'b0;
      #1;
      check("rd_done_vld", rd_isReady, 0);
      check("rd_done_canrx", st_out_canReceive, 0);
   endtask

   initial begin
      bit seen;
      rst               = 1'b1;
      ld_req            = 1'b0;
      rd_req            = '0;
      rd_canReceive     = '1;
      st_cmd_canReceive = 1'b1;
      st_out            = '0;
      st_out_isReady    = 1'b0;
      st_out_isLast     = 1'b0;
      st_in_fire_last   = 1'b0;
      #3;
      check("rst_cmd_vld", st_cmd_isReady, 0);
      check("rst_cmd", st_cmd, 0);
      check("rst_ld_ack", ld_ack, 0);
      check("rst_rd_vld", rd_isReady, 0);
      check("rst_canrx", st_out_canReceive, 0);
      check("rst_seed_valid", seed_valid, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reads without a seed stay pending.
      rd_req = 2'b01;
      seen   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (st_cmd_isReady) seen = 1'b1;
      end
      check("noseed_no_cmd", seen, 0);
      check("noseed_valid", seed_valid, 0);
      st_out = 64'hDEAD_BEEF_0123_4567;
      #1;
      check("rd_data_passthru", rd_data, 64'hDEAD_BEEF_0123_4567);
      rd_req = '0;

      do_load();

      // Both readers requesting: the grant alternates starting at 0.
      rd_req = 2'b11;
      do_read(0, 64'h1000_0000_0000_0001, 64'h1000_0000_0000_0002, 0);
      do_read(1, 64'h2000_0000_0000_0001, 64'h2000_0000_0000_0002, 0);
      do_read(0, 64'h3000_0000_0000_0001, 64'h3000_0000_0000_0002, 0);
      do_read(1, 64'h4000_0000_0000_0001, 64'h4000_0000_0000_0002, 0);

      // Backpressure on reader 1 stalls the first word for 5 cycles.
      rd_req = 2'b10;
      do_read(1, 64'h5555_AAAA_0000_0001, 64'h5555_AAAA_0000_0002, 5);

      // Load and read arriving together: the load goes first.
      ld_req = 1'b1;
      rd_req = 2'b01;
      do_load();
      do_read(0, 64'h6000_0000_0000_0001, 64'h6000_0000_0000_0002, 0);

      // Reset in the middle of a read stream.
      tick();
      check("rd6_cmd", st_cmd, SEEDA_CMD_READ);
      st_out         = 64'h7000_0000_0000_0001;
      st_out_isReady = 1'b1;
      tick();
      check("rd6_grant", rd_isReady, 2'b01);
      rst = 1'b1;
      #1;
      check("midrst_rd_vld", rd_isReady, 0);
      check("midrst_canrx", st_out_canReceive, 0);
      check("midrst_cmd_vld", st_cmd_isReady, 0);
      check("midrst_cmd", st_cmd, 0);
      check("midrst_ld_ack", ld_ack, 0);
      check("midrst_seed_valid", seed_valid, 0);
      st_out_isReady = 1'b0;
      tick();
      rst    = 1'b0;
      rd_req = 2'b11;
      seen   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (st_cmd_isReady) seen = 1'b1;
      end
      check("postrst_no_cmd", seen, 0);
      do_load();
      // The round-robin pointer was cleared, so reader 0 goes first again.
      do_read(0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0002, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
